// File: rtl/clint_mh_if.sv
// Request/response bundle between the dbus interconnect and the CLINT slave.
// Latency: none, this is wiring only.
// Backpressure: the master holds req until it sees a one-cycle ack.
//
// Signals:
//   req, w_en, addr, w_data : dbus request from the master
//   clint_sel               : slave select from the dbus address decoder
//   ack, r_data             : registered response from the slave
interface clint_mh_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  req;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           w_data;
  logic                  clint_sel;
  logic                  ack;
  logic [31:0]           r_data;

  modport master (
    output req, w_en, addr, w_data, clint_sel,
    input  ack, r_data
  );

  modport slave (
    input  req, w_en, addr, w_data, clint_sel,
    output ack, r_data
  );
endinterface

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared 64-bit mtime, per-hart mtimecmp/msip.
// Latency: ack and r_data 1 cycle after a valid access; irq outputs 1 cycle after a state change.
// Backpressure: ack is a one-cycle pulse and is never high twice in a row.
//
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   bus          : dbus slave (req/w_en/addr/w_data/clint_sel in, ack/r_data out)
//   mtime_o      : current mtime, for the time/timeh CSRs
//   timer_irq_o  : per-hart MTIP (mtime >= mtimecmp, registered)
//   soft_irq_o   : per-hart MSIP (msip bit 0)
module clint_mh #(
  parameter int NUM_HARTS    = 2,
  parameter int PRESCALE_RST = 80,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  clint_mh_if.slave            bus,
  output logic [63:0]          mtime_o,
  output logic [NUM_HARTS-1:0] timer_irq_o,
  output logic [NUM_HARTS-1:0] soft_irq_o
);

  logic [63:0]          mtime;
  logic [63:0]          mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip;
  logic                 en;
  logic [15:0]          div;
  logic [15:0]          cnt;

  logic [ADDR_WIDTH-1:0] offs;
  logic [31:0]           a;
  logic [2:0]            idx;
  logic                  is_msip, is_cmp, cmp_hi;
  logic                  is_ctrl, is_div, is_mlo, is_mhi;
  logic                  acc_vld, wr, rd, tick;
  logic [31:0]           rdata_nxt;

  assign offs = bus.addr;

  // Address decode. Both per-hart regions decode a 3-bit hart index; the
  // per-hart loops below simply find no match for h >= NUM_HARTS, which
  // gives the read-zero / write-ignored behaviour for absent harts.
  always_comb begin
    a       = 32'(offs);
    is_msip = (a[31:5] == 27'd0) && (a[1:0] == 2'b00);
    is_cmp  = (a[31:6] == 26'h100) && (a[1:0] == 2'b00);
    idx     = is_cmp ? a[5:3] : a[4:2];
    cmp_hi  = a[2];
    is_ctrl = (a == 32'h0000_BFF0);
    is_div  = (a == 32'h0000_BFF4);
    is_mlo  = (a == 32'h0000_BFF8);
    is_mhi  = (a == 32'h0000_BFFC);
  end

  // The ~ack term enforces the idle cycle between back-to-back accesses
  // while the master is still holding req from the previous one.
  assign acc_vld = bus.req & bus.clint_sel & ~bus.ack;
  assign wr      = acc_vld & bus.w_en;
  assign rd      = acc_vld & ~bus.w_en;
  assign tick    = en & (cnt == div);

  always_comb begin
    rdata_nxt = 32'd0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (idx == h[2:0]) begin
        if (is_msip) rdata_nxt = {31'd0, msip[h]};
        if (is_cmp)  rdata_nxt = cmp_hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
      end
    end
    if (is_ctrl) rdata_nxt = {31'd0, en};
    if (is_div)  rdata_nxt = {16'd0, div};
    if (is_mlo)  rdata_nxt = mtime[31:0];
    if (is_mhi)  rdata_nxt = mtime[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ack     <= 1'b0;
      bus.r_data  <= 32'd0;
      mtime       <= 64'd0;
      msip        <= '0;
      en          <= 1'b1;
      div         <= 16'(PRESCALE_RST);
      cnt         <= 16'd0;
      timer_irq_o <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      bus.ack    <= acc_vld;
      bus.r_data <= rd ? rdata_nxt : 32'd0;

      if (wr && is_ctrl) en <= bus.w_data[0];

      // A div write restarts the prescaler so the new period starts cleanly.
      if (wr && is_div) begin
        div <= bus.w_data[15:0];
        cnt <= 16'd0;
      end else if (tick) begin
        cnt <= 16'd0;
      end else if (en) begin
        cnt <= cnt + 16'd1;
      end

      // A software write to either half wins over the tick for that cycle.
      if (wr && is_mlo)      mtime[31:0]  <= bus.w_data;
      else if (wr && is_mhi) mtime[63:32] <= bus.w_data;
      else if (tick)         mtime        <= mtime + 64'd1;

      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr && idx == h[2:0]) begin
          if (is_msip) msip[h] <= bus.w_data[0];
          if (is_cmp) begin
            if (cmp_hi) mtimecmp[h][63:32] <= bus.w_data;
            else        mtimecmp[h][31:0]  <= bus.w_data;
          end
        end
        timer_irq_o[h] <= (mtime >= mtimecmp[h]);
      end
    end
  end

  assign mtime_o    = mtime;
  assign soft_irq_o = msip;

endmodule

// File: tb/tb_clint_mh.sv
// Self-checking bench for clint_mh: register-map table, timer corner cases, random traffic.
// Latency: every cycle's outputs are compared against a register-map level model.
// Backpressure: bus operations wait a bounded number of cycles for ack.
module tb_clint_mh;
  localparam int NH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   mtime_o;
  logic [NH-1:0] timer_irq_o;
  logic [NH-1:0] soft_irq_o;

  always #5 clk = ~clk;

  clint_mh_if #(.ADDR_WIDTH(16)) bus ();

  clint_mh #(.NUM_HARTS(NH), .PRESCALE_RST(80), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mtime_o(mtime_o), .timer_irq_o(timer_irq_o), .soft_irq_o(soft_irq_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: the architectural registers plus the
  // number of clocks elapsed in the current prescaler period.
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip;
  logic          m_en;
  logic [15:0]   m_div;
  int            m_phase;
  logic          m_ack;
  logic [31:0]   m_rdata;
  logic [NH-1:0] m_irq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mtime = 64'd0;
    foreach (m_cmp[i]) m_cmp[i] = '1;
    m_msip  = '0;
    m_en    = 1'b1;
    m_div   = 16'd80;
    m_phase = 0;
    m_ack   = 1'b0;
    m_rdata = 32'd0;
    m_irq   = '0;
  endtask

  function automatic logic [31:0] map_rd(input logic [15:0] a);
    int h;
    logic [31:0] r;
    r = 32'd0;
    if (a < 16'h0020) begin
      h = int'(a) / 4;
      if (h < NH) r = {31'd0, m_msip[h]};
    end else if (a >= 16'h4000 && a < 16'h4040) begin
      h = (int'(a) - 'h4000) / 8;
      if (h < NH) r = a[2] ? m_cmp[h][63:32] : m_cmp[h][31:0];
    end else begin
      case (a)
        16'hBFF0: r = {31'd0, m_en};
        16'hBFF4: r = {16'd0, m_div};
        16'hBFF8: r = m_mtime[31:0];
        16'hBFFC: r = m_mtime[63:32];
        default:  r = 32'd0;
      endcase
    end
    return r;
  endfunction

  // Advance the model across one rising edge, using the inputs in force at that edge.
  task automatic model_step();
    logic vld, tick, mt_wr, div_wr, en_old;
    logic [31:0] rdv;
    logic [15:0] a;
    int h;
    if (rst) begin
      model_reset();
    end else begin
      a      = bus.addr;
      vld    = bus.req && bus.clint_sel && !m_ack;
      rdv    = map_rd(a);
      tick   = m_en && (m_phase == int'(m_div));
      en_old = m_en;
      mt_wr  = 1'b0;
      div_wr = 1'b0;
      for (int i = 0; i < NH; i++) m_irq[i] = (m_mtime >= m_cmp[i]);
      if (vld && bus.w_en) begin
        if (a < 16'h0020) begin
          h = int'(a) / 4;
          if (h < NH) m_msip[h] = bus.w_data[0];
        end else if (a >= 16'h4000 && a < 16'h4040) begin
          h = (int'(a) - 'h4000) / 8;
          if (h < NH) begin
            if (a[2]) m_cmp[h][63:32] = bus.w_data;
            else      m_cmp[h][31:0]  = bus.w_data;
          end
        end else begin
          case (a)
            16'hBFF0: m_en = bus.w_data[0];
            16'hBFF4: begin m_div = bus.w_data[15:0]; div_wr = 1'b1; end
            16'hBFF8: begin m_mtime[31:0]  = bus.w_data; mt_wr = 1'b1; end
            16'hBFFC: begin m_mtime[63:32] = bus.w_data; mt_wr = 1'b1; end
            default: ;
          endcase
        end
      end
      if (div_wr || tick) m_phase = 0;
      else if (en_old)    m_phase = m_phase + 1;
      if (!mt_wr && tick) m_mtime = m_mtime + 64'd1;
      m_ack   = vld;
      m_rdata = (vld && !bus.w_en) ? rdv : 32'd0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("mtime_o",     mtime_o,              m_mtime);
    check("timer_irq_o", 64'(timer_irq_o),     64'(m_irq));
    check("soft_irq_o",  64'(soft_irq_o),      64'(m_msip));
    check("ack",         64'(bus.ack),         64'(m_ack));
    check("r_data",      64'(bus.r_data),      64'(m_rdata));
  endtask

  task automatic bus_op(input logic w, input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] rdat);
    logic got;
    got = 1'b0;
    rdat = 32'd0;
    bus.req = 1'b1; bus.clint_sel = 1'b1; bus.w_en = w; bus.addr = a; bus.w_data = d;
    for (int i = 0; i < 6 && !got; i++) begin
      cyc();
      if (bus.ack) begin
        got  = 1'b1;
        rdat = bus.r_data;
      end
    end
    bus.req = 1'b0; bus.clint_sel = 1'b0; bus.w_en = 1'b0;
    check("ack_seen", 64'(got), 64'd1);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_op(1'b1, a, d, dummy);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] q);
    bus_op(1'b0, a, 32'd0, q);
  endtask

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [15:0] a, input logic [31:0] d,
                              input logic [31:0] exp);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.exp = exp;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [31:0] q;
    logic [63:0] m0, prev;
    logic [5:0]  pat;
    logic        found;
    int          sel;
    logic [15:0] addrs [13];

    rst = 1'b1;
    bus.req = 1'b0; bus.clint_sel = 1'b0; bus.w_en = 1'b0; bus.addr = '0; bus.w_data = '0;
    model_reset();
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    check("rst_mtime", mtime_o, 64'd0);
    check("rst_tirq",  64'(timer_irq_o), 64'd0);
    check("rst_ack",   64'(bus.ack), 64'd0);

    // Register map table: reset values first, then write/readback pairs.
    tbl.push_back(mk(0, 16'h4000, 0, 32'hFFFF_FFFF));
    tbl.push_back(mk(0, 16'h4004, 0, 32'hFFFF_FFFF));
    tbl.push_back(mk(0, 16'hBFF8, 0, 32'h0));
    tbl.push_back(mk(0, 16'hBFF0, 0, 32'h1));
    tbl.push_back(mk(0, 16'hBFF4, 0, 32'd80));
    tbl.push_back(mk(0, 16'h400C, 0, 32'hFFFF_FFFF));
    tbl.push_back(mk(0, 16'h0000, 0, 32'h0));
    tbl.push_back(mk(0, 16'h0008, 0, 32'h0));
    tbl.push_back(mk(0, 16'h1234, 0, 32'h0));
    tbl.push_back(mk(0, 16'hBFFC, 0, 32'h0));
    tbl.push_back(mk(1, 16'h0004, 32'hFFFF_FFFF, 0));
    tbl.push_back(mk(0, 16'h0004, 0, 32'h1));
    tbl.push_back(mk(0, 16'h0000, 0, 32'h0));
    tbl.push_back(mk(1, 16'h4008, 32'h1234_5678, 0));
    tbl.push_back(mk(0, 16'h4008, 0, 32'h1234_5678));
    tbl.push_back(mk(0, 16'h400C, 0, 32'hFFFF_FFFF));
    tbl.push_back(mk(1, 16'h0008, 32'h1, 0));
    tbl.push_back(mk(0, 16'h0008, 0, 32'h0));
    tbl.push_back(mk(1, 16'h4010, 32'h5, 0));
    tbl.push_back(mk(0, 16'h4010, 0, 32'h0));
    tbl.push_back(mk(1, 16'hBFF4, 32'h0001_2345, 0));
    tbl.push_back(mk(0, 16'hBFF4, 0, 32'h2345));
    tbl.push_back(mk(1, 16'hBFF0, 32'hFFFF_FFFE, 0));
    tbl.push_back(mk(0, 16'hBFF0, 0, 32'h0));
    tbl.push_back(mk(1, 16'hBFF0, 32'h1, 0));
    tbl.push_back(mk(0, 16'hBFF0, 0, 32'h1));
    tbl.push_back(mk(1, 16'h0004, 32'h0, 0));
    tbl.push_back(mk(0, 16'h0004, 0, 32'h0));
    foreach (tbl[i]) begin
      bus_op(tbl[i].w, tbl[i].a, tbl[i].d, q);
      if (!tbl[i].w) check($sformatf("tbl_rd[%0d]", i), 64'(q), 64'(tbl[i].exp));
      cyc();
      check("ack_pulse", 64'(bus.ack), 64'd0);
    end

    // Software interrupt bit and an absent hart.
    wr(16'h0004, 32'hFFFF_FFFF); cyc();
    check("msip1_set", 64'(soft_irq_o), 64'b10);
    rd(16'h0004, q);
    check("msip1_rd", 64'(q), 64'd1);
    wr(16'h0004, 32'h0); cyc();
    check("msip1_clr", 64'(soft_irq_o), 64'b00);
    wr(16'h0008, 32'h1); cyc();
    check("msip_absent", 64'(soft_irq_o), 64'b00);

    // Timer compare at div = 0.
    wr(16'hBFF4, 32'd0);
    wr(16'h400C, 32'd0);    wr(16'h4008, 32'd10);
    wr(16'h4004, 32'd0);    wr(16'h4000, 32'd1000);
    wr(16'hBFFC, 32'd0);    wr(16'hBFF8, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      prev = mtime_o;
      cyc();
      if (mtime_o == 64'd10) check("mtip_not_early", 64'(timer_irq_o), 64'b00);
      if (prev == 64'd10) begin
        check("mtip_at_10", 64'(timer_irq_o), 64'b10);
        found = 1'b1;
      end
    end
    check("mtime_reached_10", 64'(found), 64'd1);

    // div = 3: one increment every 4 clocks; then freeze and resume.
    wr(16'hBFF4, 32'd3);
    m0 = mtime_o;
    repeat (40) cyc();
    check("div3_rate", mtime_o, m0 + 64'd10);
    wr(16'hBFF0, 32'd0);
    m0 = mtime_o;
    repeat (50) cyc();
    check("frozen", mtime_o, m0);
    wr(16'hBFF0, 32'd1);
    repeat (20) cyc();
    check("resumed", 64'(mtime_o > m0), 64'd1);

    // 64-bit wrap.
    wr(16'hBFF4, 32'd0);
    wr(16'hBFFC, 32'hFFFF_FFFF);
    wr(16'hBFF8, 32'hFFFF_FFFE);
    check("wrap_fe", mtime_o, 64'hFFFF_FFFF_FFFF_FFFE);
    cyc();
    check("wrap_ff", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc();
    check("wrap_0", mtime_o, 64'd0);
    check("irq_at_wrap", 64'(timer_irq_o), 64'b11);
    cyc();
    check("irq_after_wrap", 64'(timer_irq_o), 64'b00);

    // Req held for several cycles, then reset during an ack cycle.
    cyc();
    bus.req = 1'b1; bus.clint_sel = 1'b1; bus.w_en = 1'b0; bus.addr = 16'hBFF0;
    pat = 6'(bus.ack);
    repeat (5) begin
      cyc();
      pat = {pat[4:0], bus.ack};
    end
    check("ack_hold_pattern", 64'(pat), 64'b010101);
    rst = 1'b1;
    cyc();
    check("ack_on_rst", 64'(bus.ack), 64'd0);
    check("mtime_on_rst", mtime_o, 64'd0);
    rst = 1'b0; bus.req = 1'b0; bus.clint_sel = 1'b0;
    cyc();
    rd(16'h4000, q);
    check("cmp0_lo_after_rst", 64'(q), 64'hFFFF_FFFF);
    rd(16'h4004, q);
    check("cmp0_hi_after_rst", 64'(q), 64'hFFFF_FFFF);

    // Random traffic against the model.
    addrs = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008, 16'h400C,
              16'h4010, 16'hBFF0, 16'hBFF4, 16'hBFF8, 16'hBFFC, 16'h1000};
    for (int n = 0; n < 400; n++) begin
      logic [31:0] d;
      sel = $urandom_range(0, 12);
      case (addrs[sel])
        16'hBFF4: d = $urandom_range(0, 4);
        16'hBFF0: d = 32'($urandom_range(0, 3) != 0);
        default:  d = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 64);
      endcase
      bus_op(1'($urandom_range(0, 1)), addrs[sel], d, q);
      repeat ($urandom_range(0, 2)) cyc();
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
